segment_display_driver: RTL

SEGMENT_DISPLAY_DRIVER -- requirements
Module: segment_display_driver

---
 rtl/segment_display_driver.sv | 96 +++++++++
 1 files changed

// File: rtl/segment_display_driver.sv
// Time-multiplexed 8-digit hex driver for a 7-segment display.
// The value shown is a frame-aligned snapshot of data. Optionally, leading zeros are blanked.
module segment_display_driver #(
    parameter int unsigned SCAN_DIVIDE        = 100000,
    parameter int unsigned LEADING_ZERO_BLANK = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        blank,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        frameDone
);

    localparam int unsigned TICK_W   = (SCAN_DIVIDE > 1) ? $clog2(SCAN_DIVIDE) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SCAN_DIVIDE - 1);
    localparam logic        LZB_EN   = (LEADING_ZERO_BLANK != 0);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       shadow_q, shadow_d;
    logic              frame_c;
    logic [31:0]       upper_c;
    logic [3:0]        nibble_c;
    logic              lead_zero_c;
    logic [6:0]        glyph_c;
    logic [7:0]        anodes_d;
    logic [6:0]        segments_d;

    // Scan timing and frame-boundary snapshot
    always_comb begin
        tick_d   = tick_q + TICK_W'(1);
        idx_d    = idx_q;
        shadow_d = shadow_q;
        frame_c  = 1'b0;
        if (tick_q == TICK_MAX) begin
            tick_d = '0;
            idx_d  = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                frame_c  = 1'b1;
                shadow_d = data;
            end
        end
    end

    // Outputs are decoded from next-state values so they change together with the digit index
    always_comb begin
        upper_c     = shadow_d >> {idx_d, 2'b00};
        nibble_c    = upper_c[3:0];
        lead_zero_c = (idx_d != 3'd0) && (upper_c == 32'd0);
        case (nibble_c)
            4'h0:    glyph_c = 7'b1000000;
            4'h1:    glyph_c = 7'b1111001;
            4'h2:    glyph_c = 7'b0100100;
            4'h3:    glyph_c = 7'b0110000;
            4'h4:    glyph_c = 7'b0011001;
            4'h5:    glyph_c = 7'b0010010;
            4'h6:    glyph_c = 7'b0000010;
            4'h7:    glyph_c = 7'b1111000;
            4'h8:    glyph_c = 7'b0000000;
            4'h9:    glyph_c = 7'b0010000;
            4'hA:    glyph_c = 7'b0001000;
            4'hB:    glyph_c = 7'b0000011;
            4'hC:    glyph_c = 7'b1000110;
            4'hD:    glyph_c = 7'b0100001;
            4'hE:    glyph_c = 7'b0000110;
            default: glyph_c = 7'b0001110;
        endcase
        anodes_d   = ~(8'b1 << idx_d);
        segments_d = glyph_c;
        if (blank || (LZB_EN && lead_zero_c)) begin
            anodes_d   = 8'hFF;
            segments_d = 7'b1111111;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q    <= '0;
            idx_q     <= 3'd0;
            shadow_q  <= 32'd0;
            frameDone <= 1'b0;
            anodes    <= 8'hFE;
            segments  <= 7'b1000000;
        end else begin
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            frameDone <= frame_c;
            anodes    <= anodes_d;
            segments  <= segments_d;
        end
    end

endmodule
